// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a byte over valid/ready, latches the serial frame
// and steps the frame-bit select at the baud rate. Define UART_TX_PARITY_EN to add a parity bit.
module uart_tx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter bit          PARITY_ODD   = 1'b0,
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_W = 11
`else
  localparam int unsigned FRAME_W = 10
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [FRAME_W-1:0] frame,
  output logic [3:0]         bit_slc,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [15:0] CNT_MAX  = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  STOP_IDX = 4'(FRAME_W - 1);

  state_t             state_q, state_d;
  logic [15:0]        baud_cnt_q;
  logic [3:0]         bit_idx_q, bit_idx_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               done_q, done_d;
  logic               accept;
  logic               cnt_last;
  logic               advance;

  assign accept   = tx_valid && (state_q == S_IDLE);
  assign cnt_last = (baud_cnt_q == CNT_MAX);

`ifdef UART_TX_PARITY_EN
  assign frame_d = {1'b1, (^tx_data) ^ PARITY_ODD, tx_data, 1'b0};
`else
  assign frame_d = {1'b1, tx_data, 1'b0};
`endif

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    advance   = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_valid) state_d = S_START;
      end
      S_START: begin
        if (cnt_last) begin
          advance   = 1'b1;
          state_d   = S_DATA;
          bit_idx_d = 4'd1;
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          advance = 1'b1;
          if (bit_idx_q == 4'd8) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (cnt_last) begin
          advance = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_last) begin
          advance = 1'b1;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      frame_q    <= '1;
      done_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      done_q    <= done_d;
      if (accept || advance) begin
        baud_cnt_q <= '0;
      end else if (state_q != S_IDLE) begin
        baud_cnt_q <= baud_cnt_q + 16'd1;
      end
      if (accept) frame_q <= frame_d;
    end
  end

  // Select 4'hF in IDLE leaves the downstream mux on its default (line high).
  always_comb begin
    bit_slc = 4'hF;
    case (state_q)
      S_START:  bit_slc = 4'd0;
      S_DATA:   bit_slc = bit_idx_q;
      S_PARITY: bit_slc = 4'd9;
      S_STOP:   bit_slc = STOP_IDX;
      default:  bit_slc = 4'hF;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign tx_ready = ~busy;
  assign frame    = frame_q;
  assign done     = done_q;

endmodule
